// File: rtl/env_row_decay.sv
// env_row_decay
// -------------
// One row of the environment: PIXELS_X cells, each holding a pheromone
// signal and a sugar flag. The row has three ports. The write port
// overwrites a cell, or saturating-adds to it. The lookup and render ports
// are combinational reads. A built-in evaporation engine sweeps the row
// once per DECAY_PERIOD enabled cycles and reduces every signal by
// DECAY_STEP, clamping at zero. It visits one cell per cycle.
//
// Optional feature macro: ENV_ROW_SATURATING_ADD_EN
//   defined   : write_mode=1 selects a saturating add; the sugar flag is ORed in.
//   undefined : write_mode is ignored. Every write is an overwrite and no
//               adder is built.
//
// Ports
//   newLocClock          clock; all state changes on its rising edge
//   RESET_SIM_n          asynchronous active-low reset (clears cells, counter, FSM)
//   decay_en             enables the period counter and sweep starts
//   write_X/_flag_thisrow/_signal/_sugar/_mode   write port
//   lookup_X/_flag_thisrow -> lookup_signal/_sugar   ant lookup (combinational)
//   render_X/_flag_thisrow -> render_signal/_sugar   display read (combinational)
//   decay_busy           high while a sweep is in progress
//   sweep_done           one-cycle pulse after the last cell has been decayed
//   decay_overrun        one-cycle pulse after a period tick that was dropped
module env_row_decay #(
    parameter int PIXELS_X     = 640,
    parameter int X_bits       = $clog2(PIXELS_X),
    parameter int SIGNAL_bits  = 8,
    parameter int DECAY_PERIOD = 1024,
    parameter int DECAY_STEP   = 1
) (
    input  logic                   newLocClock,
    input  logic                   RESET_SIM_n,
    input  logic                   decay_en,
    input  logic [X_bits-1:0]      write_X,
    input  logic                   write_flag_thisrow,
    input  logic [SIGNAL_bits-1:0] write_signal,
    input  logic                   write_sugar,
    input  logic                   write_mode,
    input  logic [X_bits-1:0]      lookup_X,
    input  logic                   lookup_flag_thisrow,
    output logic [SIGNAL_bits-1:0] lookup_signal,
    output logic                   lookup_sugar,
    input  logic [X_bits-1:0]      render_X,
    input  logic                   render_flag_thisrow,
    output logic [SIGNAL_bits-1:0] render_signal,
    output logic                   render_sugar,
    output logic                   decay_busy,
    output logic                   sweep_done,
    output logic                   decay_overrun
);

    localparam int CNT_W = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
    localparam logic [SIGNAL_bits-1:0] STEP = SIGNAL_bits'(DECAY_STEP);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state_reg, state_next;
    logic [X_bits-1:0] sweep_x_reg, sweep_x_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              done_reg, done_next;
    logic              overrun_reg, overrun_next;
    logic              tick;
    logic              sweeping;

    logic [SIGNAL_bits-1:0] sig_arr [PIXELS_X];
    logic                   sug_arr [PIXELS_X];

    function automatic logic [SIGNAL_bits-1:0] decayed(input logic [SIGNAL_bits-1:0] s);
        return (s > STEP) ? (s - STEP) : '0;
    endfunction

`ifdef ENV_ROW_SATURATING_ADD_EN
    // The sum is one bit wider than a signal; its carry bit means the add saturates.
    function automatic logic [SIGNAL_bits-1:0] add_sat(input logic [SIGNAL_bits-1:0] a,
                                                       input logic [SIGNAL_bits-1:0] b);
        logic [SIGNAL_bits:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SIGNAL_bits] ? '1 : sum[SIGNAL_bits-1:0];
    endfunction
`else
    logic unused_write_mode;
    assign unused_write_mode = write_mode;
`endif

    // The counter and the FSM share one next-state process.
    always_comb begin
        cnt_next     = cnt_reg;
        tick         = 1'b0;
        state_next   = state_reg;
        sweep_x_next = sweep_x_reg;
        done_next    = 1'b0;
        overrun_next = 1'b0;

        if (decay_en) begin
            if (cnt_reg == CNT_W'(DECAY_PERIOD - 1)) begin
                cnt_next = '0;
                tick     = 1'b1;
            end else begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end

        case (state_reg)
            IDLE: begin
                if (tick) begin
                    state_next   = SWEEP;
                    sweep_x_next = '0;
                end
            end
            SWEEP: begin
                // A sweep is never restarted, so a tick that arrives while busy is lost.
                overrun_next = tick;
                if (sweep_x_reg == X_bits'(PIXELS_X - 1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    sweep_x_next = sweep_x_reg + X_bits'(1);
                end
            end
        endcase
    end

    always_ff @(posedge newLocClock or negedge RESET_SIM_n) begin
        if (!RESET_SIM_n) begin
            state_reg   <= IDLE;
            sweep_x_reg <= '0;
            cnt_reg     <= '0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sweep_x_reg <= sweep_x_next;
            cnt_reg     <= cnt_next;
            done_reg    <= done_next;
            overrun_reg <= overrun_next;
        end
    end

    assign sweeping      = (state_reg == SWEEP);
    assign decay_busy    = sweeping;
    assign sweep_done    = done_reg;
    assign decay_overrun = overrun_reg;

    // Each cell has its own update logic. An address that is out of range
    // matches no cell, so such writes are dropped without any extra logic.
    genvar gi;
    generate
        for (gi = 0; gi < PIXELS_X; gi++) begin : g_cell
            logic [SIGNAL_bits-1:0] sig_reg, sig_next;
            logic                   sug_reg, sug_next;
            logic                   wr_hit, decay_hit;

            assign wr_hit    = write_flag_thisrow && (write_X == X_bits'(gi));
            assign decay_hit = sweeping && (sweep_x_reg == X_bits'(gi));

            // The write takes priority. When it collides with the sweep, the
            // write is computed from the undecayed value. That cell then
            // misses its decay for this sweep.
            always_comb begin
                sig_next = sig_reg;
                sug_next = sug_reg;
                if (wr_hit) begin
`ifdef ENV_ROW_SATURATING_ADD_EN
                    if (write_mode) begin
                        sig_next = add_sat(sig_reg, write_signal);
                        sug_next = sug_reg | write_sugar;
                    end else begin
                        sig_next = write_signal;
                        sug_next = write_sugar;
                    end
`else
                    sig_next = write_signal;
                    sug_next = write_sugar;
`endif
                end else if (decay_hit) begin
                    sig_next = decayed(sig_reg);
                end
            end

            always_ff @(posedge newLocClock or negedge RESET_SIM_n) begin
                if (!RESET_SIM_n) begin
                    sig_reg <= '0;
                    sug_reg <= 1'b0;
                end else begin
                    sig_reg <= sig_next;
                    sug_reg <= sug_next;
                end
            end

            assign sig_arr[gi] = sig_reg;
            assign sug_arr[gi] = sug_reg;
        end
    endgenerate

    // Read ports. The range compare is done at 32 bits because X_bits may
    // be wider than PIXELS_X needs.
    logic lookup_hit, render_hit;
    assign lookup_hit = lookup_flag_thisrow && (32'(lookup_X) < PIXELS_X);
    assign render_hit = render_flag_thisrow && (32'(render_X) < PIXELS_X);

    assign lookup_signal = lookup_hit ? sig_arr[lookup_X] : '0;
    assign lookup_sugar  = lookup_hit ? sug_arr[lookup_X] : 1'b0;
    assign render_signal = render_hit ? sig_arr[render_X] : '0;
    assign render_sugar  = render_hit ? sug_arr[render_X] : 1'b0;

endmodule

// File: tb/tb_env_row_decay.sv
// Testbench for env_row_decay.
// Instance A is an 8-cell row with a 16-cycle period and a step of 2. Its
// column index is 4 bits wide, so out-of-range columns can be reached. A
// cell-level reference model checks it on every cycle.
// Instance B is an 8-cell row with an 8-cycle period. It shows the
// overrun case, where the second tick arrives while a sweep is still busy.
`timescale 1ns/1ps
module tb_env_row_decay;

    localparam int N    = 8;
    localparam int P    = 16;
    localparam int STEP = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A stimulus and outputs
    logic       en_a = 1'b0;
    logic [3:0] wx = '0;
    logic       wflag = 1'b0;
    logic [7:0] wsig = '0;
    logic       wsug = 1'b0;
    logic       wmode = 1'b0;
    logic [3:0] lx = '0, rx = '0;
    logic       lf = 1'b0, rf = 1'b0;
    logic [7:0] lsig, rsig;
    logic       lsug, rsug, busy_a, done_a, ovr_a;

    // Instance B
    logic       en_b = 1'b0;
    logic [7:0] lsig_b, rsig_b;
    logic       lsug_b, rsug_b, busy_b, done_b, ovr_b;

    env_row_decay #(.PIXELS_X(N), .X_bits(4), .SIGNAL_bits(8),
                    .DECAY_PERIOD(P), .DECAY_STEP(STEP)) dut_a (
        .newLocClock(clk), .RESET_SIM_n(rst_n), .decay_en(en_a),
        .write_X(wx), .write_flag_thisrow(wflag), .write_signal(wsig),
        .write_sugar(wsug), .write_mode(wmode),
        .lookup_X(lx), .lookup_flag_thisrow(lf),
        .lookup_signal(lsig), .lookup_sugar(lsug),
        .render_X(rx), .render_flag_thisrow(rf),
        .render_signal(rsig), .render_sugar(rsug),
        .decay_busy(busy_a), .sweep_done(done_a), .decay_overrun(ovr_a)
    );

    env_row_decay #(.PIXELS_X(8), .SIGNAL_bits(8),
                    .DECAY_PERIOD(8), .DECAY_STEP(1)) dut_b (
        .newLocClock(clk), .RESET_SIM_n(rst_n), .decay_en(en_b),
        .write_X(3'd0), .write_flag_thisrow(1'b0), .write_signal(8'd0),
        .write_sugar(1'b0), .write_mode(1'b0),
        .lookup_X(3'd0), .lookup_flag_thisrow(1'b0),
        .lookup_signal(lsig_b), .lookup_sugar(lsug_b),
        .render_X(3'd0), .render_flag_thisrow(1'b0),
        .render_signal(rsig_b), .render_sugar(rsug_b),
        .decay_busy(busy_b), .sweep_done(done_b), .decay_overrun(ovr_b)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model. m_pos is the column the sweep will process on the
    // next edge, or -1 when no sweep is running. en_cnt counts enabled
    // edges; every P-th one is a tick.
    int m_sig [N];
    bit m_sug [N];
    int m_pos;
    int en_cnt;
    bit exp_done, exp_ovr;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_sig[i] = 0;
            m_sug[i] = 1'b0;
        end
        m_pos = -1;
        en_cnt = 0;
        exp_done = 1'b0;
        exp_ovr = 1'b0;
    endtask

    task automatic model_edge();
        int  wi;
        bit  tick;
        wi = (wflag && wx < N) ? int'(wx) : -1;
        if (m_pos >= 0 && m_pos != wi)
            m_sig[m_pos] = (m_sig[m_pos] > STEP) ? m_sig[m_pos] - STEP : 0;
        if (wi >= 0) begin
`ifdef ENV_ROW_SATURATING_ADD_EN
            if (wmode) begin
                m_sig[wi] = (m_sig[wi] + int'(wsig) > 255) ? 255 : m_sig[wi] + int'(wsig);
                m_sug[wi] = m_sug[wi] | wsug;
            end else begin
                m_sig[wi] = int'(wsig);
                m_sug[wi] = wsug;
            end
`else
            m_sig[wi] = int'(wsig);
            m_sug[wi] = wsug;
`endif
        end
        exp_done = (m_pos == N - 1);
        exp_ovr = 1'b0;
        tick = 1'b0;
        if (en_a) begin
            en_cnt++;
            tick = (en_cnt % P == 0);
        end
        if (m_pos >= 0) begin
            exp_ovr = tick;
            m_pos = (m_pos == N - 1) ? -1 : m_pos + 1;
        end else if (tick) begin
            m_pos = 0;
        end
    endtask

    function automatic int exp_read(input logic f, input logic [3:0] x);
        return (f && x < N) ? m_sig[x] : 0;
    endfunction

    function automatic bit exp_rsug(input logic f, input logic [3:0] x);
        return (f && x < N) ? m_sug[x] : 1'b0;
    endfunction

    // One clock edge for instance A, followed by a full check against the model.
    task automatic step_a();
        @(posedge clk);
        model_edge();
        cyc++;
        $display("cyc %0d wr=%0b x=%0d sig=%02h mode=%0b en=%0b busy=%0b", cyc, wflag, wx, wsig, wmode, en_a, busy_a);
        #1;
        lx = 4'($urandom_range(0, 15));
        lf = ($urandom_range(0, 3) != 0);
        rx = 4'($urandom_range(0, 15));
        rf = ($urandom_range(0, 3) != 0);
        #1;
        check("busy", 32'(busy_a), 32'(m_pos >= 0));
        check("sweep_done", 32'(done_a), 32'(exp_done));
        check("overrun", 32'(ovr_a), 32'(exp_ovr));
        check("lookup_sig", 32'(lsig), exp_read(lf, lx));
        check("lookup_sugar", 32'(lsug), 32'(exp_rsug(lf, lx)));
        check("render_sig", 32'(rsig), exp_read(rf, rx));
        check("render_sugar", 32'(rsug), 32'(exp_rsug(rf, rx)));
    endtask

    task automatic do_write(input logic [3:0] x, input logic [7:0] s, input logic su, input logic m);
        wx = x; wsig = s; wsug = su; wmode = m; wflag = 1'b1;
        step_a();
        wflag = 1'b0;
    endtask

    task automatic look(input string tag, input logic [3:0] x, input int es, input bit esu);
        lx = x; lf = 1'b1;
        #1;
        check(tag, 32'(lsig), es);
        check({tag, "_sugar"}, 32'(lsug), 32'(esu));
    endtask

    task automatic async_reset();
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_ovr", 32'(ovr_a), 0);
        for (int i = 0; i < N; i++) begin
            lx = 4'(i); lf = 1'b1;
            #1 check("rst_cell", 32'(lsig), 0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        int cnt, busy_cnt, done_cnt;
        bit eb, eo;
        model_reset();

        // Values immediately after reset
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy_a", 32'(busy_a), 0);
        check("reset_busy_b", 32'(busy_b), 0);
        look("reset_cell3", 4'd3, 0, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        // Instance B: the tick at edge 16 arrives while busy and is dropped
        en_b = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            eb = (k >= 8 && k < 16) || (k >= 24);
            eo = (k == 16);
            check("b_busy", 32'(busy_b), 32'(eb));
            check("b_overrun", 32'(ovr_b), 32'(eo));
            check("b_done", 32'(done_b), 32'(eo));
        end
        en_b = 1'b0;

        // Overwrite, reads, port flag and out-of-range behaviour
        do_write(4'd3, 8'h40, 1'b1, 1'b0);
        look("cell3", 4'd3, 'h40, 1'b1);
        rx = 4'd4; rf = 1'b1;
        #1 check("render4", 32'(rsig), 0);
        lx = 4'd3; lf = 1'b0;
        #1 check("lookup_flag0", 32'(lsig), 0);
        do_write(4'd11, 8'h77, 1'b1, 1'b0);
        look("out_of_range_read", 4'd11, 0, 1'b0);

        // Saturating add, or overwrite when the feature is not built
        do_write(4'd5, 8'hF0, 1'b0, 1'b0);
        do_write(4'd5, 8'h20, 1'b0, 1'b1);
`ifdef ENV_ROW_SATURATING_ADD_EN
        look("add_sat", 4'd5, 'hFF, 1'b0);
`else
        look("add_sat", 4'd5, 'h20, 1'b0);
`endif
        do_write(4'd6, 8'h10, 1'b1, 1'b0);
        do_write(4'd6, 8'h01, 1'b0, 1'b1);
`ifdef ENV_ROW_SATURATING_ADD_EN
        look("add_plain", 4'd6, 'h11, 1'b1);
`else
        look("add_plain", 4'd6, 'h01, 1'b0);
`endif

        // Sweep timing and decay values
        async_reset();
        do_write(4'd0, 8'd1, 1'b0, 1'b0);
        do_write(4'd1, 8'd5, 1'b1, 1'b0);
        en_a = 1'b1;
        cnt = 0;
        while (!busy_a && cnt < 40) begin step_a(); cnt++; end
        check("first_sweep_edge", cnt, P);
        busy_cnt = 0; done_cnt = 0;
        while (busy_a && busy_cnt < 40) begin step_a(); busy_cnt++; done_cnt += int'(done_a); end
        check("busy_cycles", busy_cnt, N);
        check("done_pulses", done_cnt, 1);
        look("decay0", 4'd0, 0, 1'b0);
        look("decay1", 4'd1, 3, 1'b1);

        // A write collides with the sweep at column 2
        cnt = 0;
        while (!busy_a && cnt < 40) begin step_a(); cnt++; end
        step_a();
        step_a();
        do_write(4'd2, 8'h30, 1'b0, 1'b0);
        cnt = 0;
        while (busy_a && cnt < 40) begin step_a(); cnt++; end
        look("collision2", 4'd2, 'h30, 1'b0);
        look("neighbour1", 4'd1, 1, 1'b1);

        // Random traffic
        for (int t = 0; t < 300; t++) begin
            wflag = ($urandom_range(0, 2) == 0);
            wx    = 4'($urandom_range(0, 15));
            wsig  = 8'($urandom);
            wsug  = 1'($urandom);
            wmode = 1'($urandom);
            en_a  = ($urandom_range(0, 7) != 0);
            step_a();
        end
        wflag = 1'b0;

        // Asynchronous reset in the middle of a sweep
        en_a = 1'b1;
        cnt = 0;
        while (!busy_a && cnt < 40) begin step_a(); cnt++; end
        step_a();
        async_reset();
        cnt = 0;
        while (!busy_a && cnt < 40) begin step_a(); cnt++; end
        check("sweep_after_reset", cnt, P);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
